// File: rtl/intc_vectored.sv
// Vectored interrupt controller: edge-latched pending bits, enable mask,
// fixed lowest-index-first priority and an IRQ/IACK handshake FSM.
module intc_vectored #(
  parameter int                NUM_CH    = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h00020000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] done,
  input  logic              IACK,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              IRQ,
  output logic [DATA_W-1:0] isr_addr,
  output logic [3:0]        irq_id,
  output logic              error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic [DATA_W-1:0] vec_q [NUM_CH];
  logic [DATA_W-1:0] vec_d [NUM_CH];
  logic [DATA_W-1:0] isrAddr_q, isrAddr_d;
  logic [3:0]        irqId_q, irqId_d;
  logic              error_q, error_d;

  logic              hit, aligned, wrHit, badWrite;
  logic              isVec, isEn, isPend, isStat;
  logic [7:0]        off;
  logic [NUM_CH-1:0] rise, eligible, w1cMask, ackMask;
  logic [3:0]        winner;
  logic [DATA_W-1:0] winnerVec, rdVec;
  logic              ackClear, iackErr;

  // Address decode: window hit plus which register the offset selects.
  always_comb begin
    off      = input_addr[7:0];
    hit      = (input_addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
    aligned  = (off[1:0] == 2'b00);
    isVec    = aligned && (off[7:6] == 2'b00) && ({1'b0, off[5:2]} < 5'(NUM_CH));
    isEn     = (off == 8'h40);
    isPend   = (off == 8'h44);
    isStat   = (off == 8'h48);
    wrHit    = write_enable && hit;
    badWrite = wrHit && !(isVec || isEn || isPend || isStat);
  end

  // Fixed priority arbitration: scanning downward leaves the lowest eligible index.
  always_comb begin
    rise      = done & ~done_q;
    eligible  = pending_q & enable_q;
    winner    = 4'd0;
    winnerVec = '0;
    ackMask   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner    = 4'(i);
        winnerVec = vec_q[i];
      end
      if (irqId_q == 4'(i)) ackMask[i] = 1'b1;
    end
  end

  // Request FSM: latch the winner in IDLE, hold it through REQ, wait out IACK in ACK.
  always_comb begin
    state_d   = state_q;
    irqId_d   = irqId_q;
    isrAddr_d = isrAddr_q;
    ackClear  = 1'b0;
    iackErr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (IACK) iackErr = 1'b1;
        if (|eligible) begin
          irqId_d   = winner;
          isrAddr_d = winnerVec;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (IACK) begin
          ackClear = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        if (!IACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register-file updates; a new rising edge always beats a same-cycle clear.
  always_comb begin
    w1cMask   = (wrHit && isPend) ? write_data[NUM_CH-1:0] : '0;
    pending_d = (pending_q & ~(w1cMask | (ackClear ? ackMask : '0))) | rise;
    enable_d  = (wrHit && isEn) ? write_data[NUM_CH-1:0] : enable_q;
    error_d   = (error_q & ~(wrHit && isStat && write_data[0])) | badWrite | iackErr;
    for (int i = 0; i < NUM_CH; i++) begin
      vec_d[i] = vec_q[i];
      if (wrHit && isVec && (off[5:2] == 4'(i))) vec_d[i] = write_data;
    end
  end

  // State registers, all cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      isrAddr_q <= '0;
      irqId_q   <= '0;
      error_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) vec_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      isrAddr_q <= isrAddr_d;
      irqId_q   <= irqId_d;
      error_q   <= error_d;
      for (int i = 0; i < NUM_CH; i++) vec_q[i] <= vec_d[i];
    end
  end

  // Combinational read mux; unmapped offsets and addresses outside the window read 0.
  always_comb begin
    rdVec     = '0;
    read_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (off[5:2] == 4'(i)) rdVec = vec_q[i];
    end
    if (hit) begin
      if (isVec) begin
        read_data = rdVec;
      end else if (isEn) begin
        read_data = DATA_W'(enable_q);
      end else if (isPend) begin
        read_data = DATA_W'(pending_q);
      end else if (isStat) begin
        read_data[7:4] = irqId_q;
        read_data[1]   = (state_q == REQ);
        read_data[0]   = error_q;
      end
    end
  end

  assign IRQ      = (state_q == REQ);
  assign isr_addr = isrAddr_q;
  assign irq_id   = irqId_q;
  assign error    = error_q;

endmodule

// File: tb/tb_intc_vectored.sv
// Directed bench for intc_vectored: register access, priority, masking,
// error flag and asynchronous reset, with hand-computed expectations.
module tb_intc_vectored;

  localparam logic [31:0] BASE = 32'h00020000;

  logic        clk;
  logic        rst;
  logic [3:0]  done;
  logic        IACK;
  logic [31:0] input_addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        IRQ;
  logic [31:0] isr_addr;
  logic [3:0]  irq_id;
  logic        error;

  int compared;
  int mismatched;

  intc_vectored dut (
    .clk          (clk),
    .rst          (rst),
    .done         (done),
    .IACK         (IACK),
    .input_addr   (input_addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .IRQ          (IRQ),
    .isr_addr     (isr_addr),
    .irq_id       (irq_id),
    .error        (error)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one bus write; returns at the falling edge after the write edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    input_addr   = addr;
    write_data   = data;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic checkRead(input string tag, input logic [7:0] offset, input logic [31:0] expected);
    input_addr = BASE + 32'(offset);
    #1;
    checkOutput(tag, read_data, expected);
  endtask

  task automatic pulseDone(input logic [3:0] mask);
    @(negedge clk);
    done = mask;
    @(negedge clk);
    done = 4'b0000;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    done         = 4'b0000;
    IACK         = 1'b0;
    input_addr   = BASE;
    write_enable = 1'b0;
    write_data   = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Reset state
    checkRead("rst_vec0", 8'h00, 32'h0);
    checkRead("rst_vec1", 8'h04, 32'h0);
    checkRead("rst_vec2", 8'h08, 32'h0);
    checkRead("rst_vec3", 8'h0C, 32'h0);
    checkRead("rst_enable", 8'h40, 32'h0);
    checkRead("rst_pending", 8'h44, 32'h0);
    checkRead("rst_status", 8'h48, 32'h0);
    checkOutput("rst_irq", 32'(IRQ), 32'h0);
    checkOutput("rst_error", 32'(error), 32'h0);

    // Vector and mask setup, single source
    applyStimulus(BASE + 32'h08, 32'h00001200);
    applyStimulus(BASE + 32'h40, 32'h0000000F);
    checkRead("vec2_rb", 8'h08, 32'h00001200);
    checkRead("enable_rb", 8'h40, 32'h0000000F);
    @(negedge clk);
    done = 4'b0100;
    @(negedge clk);
    done = 4'b0000;
    checkRead("ch2_pending", 8'h44, 32'h4);
    checkOutput("ch2_irq_early", 32'(IRQ), 32'h0);
    @(negedge clk);
    checkOutput("ch2_irq", 32'(IRQ), 32'h1);
    checkOutput("ch2_isr", isr_addr, 32'h00001200);
    checkOutput("ch2_id", 32'(irq_id), 32'h2);
    checkRead("ch2_status", 8'h48, 32'h22);
    IACK = 1'b1;
    @(negedge clk);
    checkOutput("ch2_irq_ack", 32'(IRQ), 32'h0);
    checkRead("ch2_pending_ack", 8'h44, 32'h0);
    IACK = 1'b0;
    @(negedge clk);
    checkOutput("ch2_isr_hold", isr_addr, 32'h00001200);

    // Priority between simultaneous sources
    applyStimulus(BASE + 32'h00, 32'h00000100);
    applyStimulus(BASE + 32'h0C, 32'h00000300);
    pulseDone(4'b1001);
    checkRead("prio_pending", 8'h44, 32'h9);
    @(negedge clk);
    checkOutput("prio1_irq", 32'(IRQ), 32'h1);
    checkOutput("prio1_isr", isr_addr, 32'h00000100);
    checkOutput("prio1_id", 32'(irq_id), 32'h0);
    IACK = 1'b1;
    @(negedge clk);
    checkOutput("prio1_irq_ack", 32'(IRQ), 32'h0);
    checkRead("prio1_pending", 8'h44, 32'h8);
    @(negedge clk);
    checkOutput("prio_ack_wait", 32'(IRQ), 32'h0);
    IACK = 1'b0;
    @(negedge clk);
    checkOutput("prio_idle", 32'(IRQ), 32'h0);
    @(negedge clk);
    checkOutput("prio2_irq", 32'(IRQ), 32'h1);
    checkOutput("prio2_isr", isr_addr, 32'h00000300);
    checkOutput("prio2_id", 32'(irq_id), 32'h3);
    applyStimulus(BASE + 32'h0C, 32'h00000ABC);
    checkOutput("prio2_isr_stable", isr_addr, 32'h00000300);
    checkOutput("prio2_irq_held", 32'(IRQ), 32'h1);
    IACK = 1'b1;
    @(negedge clk);
    IACK = 1'b0;
    @(negedge clk);
    checkRead("prio_pending_done", 8'h44, 32'h0);

    // Masking
    applyStimulus(BASE + 32'h40, 32'h0);
    pulseDone(4'b0010);
    checkRead("mask_pending", 8'h44, 32'h2);
    @(negedge clk);
    checkOutput("mask_irq_off", 32'(IRQ), 32'h0);
    applyStimulus(BASE + 32'h40, 32'h2);
    checkOutput("unmask_irq_early", 32'(IRQ), 32'h0);
    @(negedge clk);
    checkOutput("unmask_irq", 32'(IRQ), 32'h1);
    checkOutput("unmask_id", 32'(irq_id), 32'h1);
    checkOutput("unmask_isr", isr_addr, 32'h0);
    IACK = 1'b1;
    @(negedge clk);
    IACK = 1'b0;
    @(negedge clk);
    applyStimulus(BASE + 32'h40, 32'h0);
    pulseDone(4'b0010);
    checkRead("w1c_before", 8'h44, 32'h2);
    applyStimulus(BASE + 32'h44, 32'h2);
    checkRead("w1c_after", 8'h44, 32'h0);
    applyStimulus(BASE + 32'h40, 32'h2);
    repeat (3) @(negedge clk);
    checkOutput("w1c_no_irq", 32'(IRQ), 32'h0);

    // Error flag
    IACK = 1'b1;
    @(negedge clk);
    IACK = 1'b0;
    checkOutput("iack_idle_err", 32'(error), 32'h1);
    checkRead("iack_idle_status", 8'h48, 32'h11);
    applyStimulus(BASE + 32'h48, 32'h1);
    checkOutput("err_clear", 32'(error), 32'h0);
    applyStimulus(BASE + 32'h40, 32'h0);
    pulseDone(4'b0001);
    applyStimulus(BASE + 32'h45, 32'h1);
    checkOutput("misalign_err", 32'(error), 32'h1);
    checkRead("misalign_ignored", 8'h44, 32'h1);
    applyStimulus(BASE + 32'h48, 32'h1);
    checkOutput("err_clear2", 32'(error), 32'h0);
    applyStimulus(BASE + 32'h4C, 32'h0);
    checkOutput("unmapped_err", 32'(error), 32'h1);
    applyStimulus(BASE + 32'h48, 32'h1);
    applyStimulus(BASE + 32'h10, 32'h5);
    checkOutput("vec_oob_err", 32'(error), 32'h1);
    applyStimulus(BASE + 32'h48, 32'h1);
    applyStimulus(BASE + 32'h140, 32'hF);
    checkOutput("outside_no_err", 32'(error), 32'h0);
    checkRead("outside_ignored", 8'h40, 32'h0);

    // Asynchronous reset in the middle of a request
    IACK = 1'b1;
    @(negedge clk);
    IACK = 1'b0;
    applyStimulus(BASE + 32'h40, 32'h1);
    @(negedge clk);
    checkOutput("pre_rst_irq", 32'(IRQ), 32'h1);
    checkOutput("pre_rst_isr", isr_addr, 32'h00000100);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_irq", 32'(IRQ), 32'h0);
    checkOutput("async_rst_err", 32'(error), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    checkRead("post_rst_vec0", 8'h00, 32'h0);
    checkRead("post_rst_vec2", 8'h08, 32'h0);
    checkRead("post_rst_enable", 8'h40, 32'h0);
    checkRead("post_rst_pending", 8'h44, 32'h0);
    checkRead("post_rst_status", 8'h48, 32'h0);
    checkOutput("post_rst_isr", isr_addr, 32'h0);
    checkOutput("post_rst_id", 32'(irq_id), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
